// File: rtl/difftest_mhpm_pkg.sv
// Shared constants for the difftest hpm-counter overflow event source.
package difftest_mhpm_pkg;

    localparam int unsigned OVF_W_DEFAULT = 64;
    localparam int unsigned COAL_W        = 16;

    // Capturable counters: mhpmcounter3..31; cycle/time/instret and bits >= 32 never report.
    localparam int unsigned LEGAL_LO = 3;
    localparam int unsigned LEGAL_HI = 32;

    localparam logic [63:0] LEGAL_MASK =
        ((64'd1 << LEGAL_HI) - 64'd1) & ~((64'd1 << LEGAL_LO) - 64'd1);

    function automatic logic legal_bit(input int unsigned idx);
        return (idx >= LEGAL_LO) && (idx < LEGAL_HI);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter with selectable saturate-at-max or modulo-wrap behaviour.
module sat_counter #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = (count == '1);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !(SATURATE && at_max)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/difftest_mhpm_overflow_source.sv
// Coalesces per-counter overflow strobes into single-entry difftest overflow events.
module difftest_mhpm_overflow_source
    import difftest_mhpm_pkg::*;
#(
    parameter int unsigned OVF_W  = OVF_W_DEFAULT,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OVF_W-1:0]  io_ovf_pulse,
    input  logic [OVF_W-1:0]  io_ovf_en,
    input  logic [7:0]        io_coreid_in,
    input  logic              io_out_ready,
    output logic              io_out_valid,
    output logic [OVF_W-1:0]  io_out_mhpmeventOverflow,
    output logic [7:0]        io_out_coreid,
    output logic [STAT_W-1:0] io_stat_events,
    output logic [COAL_W-1:0] io_stat_coalesced
);

    logic [OVF_W-1:0] legal_mask;
    logic [OVF_W-1:0] captured;
    logic [OVF_W-1:0] pending;
    logic [OVF_W-1:0] merged;
    logic [OVF_W-1:0] out_vec;
    logic [7:0]       out_coreid;
    logic             out_valid;
    logic             fire;
    logic             empty;
    logic             coalesce;

    for (genvar g = 0; g < OVF_W; g++) begin : g_mask
        assign legal_mask[g] = legal_bit(g);
    end

    assign captured = io_ovf_pulse & io_ovf_en & legal_mask;
    assign merged   = pending | captured;
    assign fire     = out_valid & io_out_ready;
    assign empty    = !out_valid || fire;
    // pending is only non-zero while stalled, so one check covers both stall and load merges.
    assign coalesce = |(captured & pending);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_coreid <= '0;
            pending    <= '0;
        end else if (empty) begin
            if (merged != '0) begin
                out_valid  <= 1'b1;
                out_vec    <= merged;
                out_coreid <= io_coreid_in;
                pending    <= '0;
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            pending <= merged;
        end
    end

    sat_counter #(
        .WIDTH    (STAT_W),
        .SATURATE (1'b0)
    ) u_events (
        .clock (clock),
        .reset (reset),
        .inc   (fire),
        .count (io_stat_events)
    );

    sat_counter #(
        .WIDTH    (COAL_W),
        .SATURATE (1'b1)
    ) u_coalesced (
        .clock (clock),
        .reset (reset),
        .inc   (coalesce),
        .count (io_stat_coalesced)
    );

    assign io_out_valid             = out_valid;
    assign io_out_mhpmeventOverflow = out_vec;
    assign io_out_coreid            = out_coreid;

endmodule

// File: doc/difftest_mhpm_overflow_source.md
DIFFTEST_MHPM_OVERFLOW_SOURCE -- requirements
Module: difftest_mhpm_overflow_source

Interface
Parameters (name, default, meaning):
REQ-001 The module SHALL have parameter OVF_W, default 64, giving the overflow vector width, matching the difftest overflow-event payload.
REQ-002 The module SHALL have parameter STAT_W, default 32, giving the emitted-event counter width.
Ports (name, direction, width, meaning):
REQ-003 The module SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 The module SHALL have port io_ovf_pulse, input, OVF_W, one-cycle per-counter overflow strobes from the hpm counters.
REQ-006 The module SHALL have port io_ovf_en, input, OVF_W, the per-bit capture enable; a pulse on a disabled bit is ignored.
REQ-007 The module SHALL have port io_coreid_in, input, 8, the hart id, sampled at event load.
REQ-008 The module SHALL have port io_out_ready, input, 1, sink acceptance from the difftest batching stage.
REQ-009 The module SHALL have port io_out_valid, output, 1, event present; it drives the sink's io_valid/enable.
REQ-010 The module SHALL have port io_out_mhpmeventOverflow, output, OVF_W, the coalesced overflow bit vector.
REQ-011 The module SHALL have port io_out_coreid, output, 8, the hart id captured with the event.
REQ-012 The module SHALL have port io_stat_events, output, STAT_W, the count of accepted events.
REQ-013 The module SHALL have port io_stat_coalesced, output, 16, the count of cycles in which a re-overflow merged into a pending bit.

Function
REQ-014 The module SHALL compute the captured pulses as new = io_ovf_pulse & io_ovf_en & LEGAL_MASK, where LEGAL_MASK forces bits [2:0] (cycle/time/instret) and bits [OVF_W-1:32] to zero.
REQ-015 The module SHALL define fire as io_out_valid & io_out_ready.
REQ-016 The module SHALL treat the output stage as empty when io_out_valid=0 or fire=1.
REQ-017 When the output stage is empty and (pending|new)!=0, the module SHALL, at the next edge, load out_vec=pending|new, out_coreid=io_coreid_in, set io_out_valid=1 and clear pending.
REQ-018 When the output stage is empty and (pending|new)==0, the module SHALL deassert io_out_valid at the next edge.
REQ-019 When the output stage is stalled (valid=1, ready=0), the module SHALL hold the outputs stable and set pending=pending|new.
REQ-020 The module SHALL have a latency of exactly 1 cycle from a pulse to io_out_valid when the output stage is empty.
REQ-021 The module SHALL sustain one event per cycle under continuous ready and pulses.
REQ-022 The module SHALL never drop a pulse; at most one bit-set per counter is held between emissions.
REQ-023 The module SHALL increment io_stat_coalesced, saturating at 0xFFFF, in each cycle where (new & pending)!=0 while stalled, or (new & pending)!=0 while loading.
REQ-024 The module SHALL increment io_stat_events on each fire, wrapping modulo 2^STAT_W.
REQ-025 The module SHALL keep io_out_valid high until fire (no retraction while stalled).

Reset
REQ-026 While reset=1, the module SHALL force at the edge: io_out_valid=0, out_vec=0, out_coreid=0, pending=0, io_stat_events=0, io_stat_coalesced=0.
REQ-027 Pulses present in a reset cycle SHALL be discarded.
REQ-028 Reset mid-stall SHALL discard the held event and pending bits with no emission.

Structure
REQ-029 A shared package difftest_mhpm_pkg SHALL hold LEGAL_MASK, the OVF_W default and the coalesced-counter width 16.
REQ-030 The design SHALL use a single sub-module, sat_counter (parameterised width, saturate/wrap select), instantiated for both statistics counters.
REQ-031 io_out_* SHALL connect directly to the difftest overflow-event sink (io_valid, io_mhpmeventOverflow, io_coreid) with no extra logic.

Verification
REQ-032 Scenario: pulse=0x8 with en=all-ones and ready=1 -> next cycle valid=1, vec=0x8; following cycle valid=0; events=1.
REQ-033 Scenario: ready=0 while pulse 0x10 arrives at t0 and 0x20 at t1 -> held vec stays 0x10; after ready=1 at t3, next event vec=0x20; events=2.
REQ-034 Scenario: while stalled, bit 5 pulses twice -> coalesced=1 and a single later event carries 0x20.
REQ-035 Scenario: pulse=0xFFFFFFFF_FFFFFFFF, en=all-ones -> vec=0x00000000_FFFFFFF8.
REQ-036 Scenario: reset asserted while valid=1, ready=0, pending=0x40 -> after reset, valid=0 and counters=0; no event with 0x40 is ever emitted.
REQ-037 Scenario: pulses every cycle with ready=1 for 100 cycles -> 100 back-to-back fires and events=100.
